// File: rtl/icache_ctrl_seq_pkg.sv
// Shared definitions for the icache control sequencer: register map, STATUS layout and FSM states.
package icache_ctrl_seq_pkg;

  // Word offsets, i.e. add_i[4:2]
  localparam logic [2:0] RegEnable   = 3'd0;
  localparam logic [2:0] RegFlush    = 3'd1;
  localparam logic [2:0] RegSelFlush = 3'd2;
  localparam logic [2:0] RegPfAddr   = 3'd3;
  localparam logic [2:0] RegPfStart  = 3'd4;
  localparam logic [2:0] RegStatus   = 3'd5;

  localparam int unsigned StatusBypassBit = 0;
  localparam int unsigned StatusBusyBit   = 1;
  localparam int unsigned StatusPfBusyBit = 2;

  typedef enum logic [2:0] {
    StIdle,
    StByp,
    StFlush,
    StSel,
    StPfReq,
    StPfWait
  } state_e;

  // Writes to these registers start a cache command and may only be accepted while idle.
  function automatic logic is_cmd_reg(logic [2:0] idx);
    return (idx == RegEnable) || (idx == RegFlush) || (idx == RegSelFlush) || (idx == RegPfStart);
  endfunction

endpackage

// File: rtl/icache_ctrl_seq_regif.sv
// Peripheral slave side: register decode, grant/stall, PF_ADDR shadow and the one-cycle response.
module icache_ctrl_seq_regif
  import icache_ctrl_seq_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [31:0]         add,
  input  logic                wen,
  input  logic [31:0]         wdata,
  input  logic [ID_WIDTH-1:0] id,
  input  logic                idle,
  input  logic                bypass,
  input  logic                busy,
  input  logic                pf_busy,
  output logic                gnt,
  output logic                r_valid,
  output logic                r_opc,
  output logic [ID_WIDTH-1:0] r_id,
  output logic [31:0]         r_rdata,
  output logic                wr_enable,
  output logic                wr_flush,
  output logic                wr_sel_flush,
  output logic                wr_pf_start,
  output logic [31:0]         pf_addr_shadow
);

  logic [2:0]  idx;
  logic        is_cmd;
  logic        unmapped;
  logic        wr;
  logic [31:0] rdata;
  logic        unused_add;

  assign idx        = add[4:2];
  assign unused_add = ^{add[31:5], add[1:0]};

  always_comb begin
    is_cmd       = ~wen & is_cmd_reg(idx);
    unmapped     = idx > RegStatus;
    gnt          = req & (~is_cmd | idle);
    wr           = gnt & ~wen;
    wr_enable    = wr & (idx == RegEnable);
    wr_flush     = wr & (idx == RegFlush);
    wr_sel_flush = wr & (idx == RegSelFlush);
    wr_pf_start  = wr & (idx == RegPfStart);

    rdata = '0;
    case (idx)
      RegEnable: rdata[0] = ~bypass;
      RegPfAddr: rdata    = pf_addr_shadow;
      RegStatus: begin
        rdata[StatusBypassBit] = bypass;
        rdata[StatusBusyBit]   = busy;
        rdata[StatusPfBusyBit] = pf_busy;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid        <= 1'b0;
      r_opc          <= 1'b0;
      r_id           <= '0;
      r_rdata        <= '0;
      pf_addr_shadow <= '0;
    end else begin
      r_valid <= gnt;
      r_opc   <= gnt & unmapped;
      r_id    <= gnt ? id : '0;
      r_rdata <= (gnt & wen) ? rdata : '0;
      if (wr && idx == RegPfAddr) begin
        pf_addr_shadow <= wdata;
      end
    end
  end

endmodule

// File: rtl/icache_ctrl_seq.sv
// Icache control front end: turns register writes into bypass/flush/sel-flush/prefetch handshakes,
// one at a time, with registered request outputs toward the cache.
module icache_ctrl_seq
  import icache_ctrl_seq_pkg::*;
#(
  parameter int unsigned NB_CORES = 8,
  parameter int unsigned ID_WIDTH = NB_CORES + 1,
  parameter logic        BYP_RST  = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic [31:0]         add_i,
  input  logic                wen_i,
  input  logic [31:0]         wdata_i,
  input  logic [3:0]          be_i,
  input  logic [ID_WIDTH-1:0] id_i,
  output logic                gnt_o,
  output logic                r_valid_o,
  output logic                r_opc_o,
  output logic [ID_WIDTH-1:0] r_id_o,
  output logic [31:0]         r_rdata_o,
  output logic                bypass_req_o,
  input  logic [NB_CORES:0]   bypass_ack_i,
  output logic                flush_req_o,
  input  logic                flush_ack_i,
  output logic                sel_flush_req_o,
  output logic [31:0]         sel_flush_addr_o,
  input  logic                sel_flush_ack_i,
  output logic                pf_req_o,
  output logic [31:0]         pf_addr_o,
  output logic [7:0]          pf_size_o,
  input  logic                pf_ack_i,
  input  logic                pf_done_i
);

  state_e      state_q;
  logic        idle;
  logic        pf_busy;
  logic        wr_enable;
  logic        wr_flush;
  logic        wr_sel_flush;
  logic        wr_pf_start;
  logic [31:0] pf_addr_shadow;
  logic        unused_be;

  assign idle      = state_q == StIdle;
  assign pf_busy   = (state_q == StPfReq) || (state_q == StPfWait);
  assign unused_be = ^be_i;

  icache_ctrl_seq_regif #(
    .ID_WIDTH (ID_WIDTH)
  ) u_regif (
    .clk            (clk_i),
    .rst            (rst_i),
    .req            (req_i),
    .add            (add_i),
    .wen            (wen_i),
    .wdata          (wdata_i),
    .id             (id_i),
    .idle           (idle),
    .bypass         (bypass_req_o),
    .busy           (~idle),
    .pf_busy        (pf_busy),
    .gnt            (gnt_o),
    .r_valid        (r_valid_o),
    .r_opc          (r_opc_o),
    .r_id           (r_id_o),
    .r_rdata        (r_rdata_o),
    .wr_enable      (wr_enable),
    .wr_flush       (wr_flush),
    .wr_sel_flush   (wr_sel_flush),
    .wr_pf_start    (wr_pf_start),
    .pf_addr_shadow (pf_addr_shadow)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= StIdle;
      bypass_req_o     <= BYP_RST;
      flush_req_o      <= 1'b0;
      sel_flush_req_o  <= 1'b0;
      sel_flush_addr_o <= '0;
      pf_req_o         <= 1'b0;
      pf_addr_o        <= '0;
      pf_size_o        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // ENABLE bit0 is the inverse of bypass; an unchanged mode needs no handshake.
          if (wr_enable && (wdata_i[0] == bypass_req_o)) begin
            bypass_req_o <= ~wdata_i[0];
            state_q      <= StByp;
          end else if (wr_flush) begin
            state_q <= StFlush;
          end else if (wr_sel_flush) begin
            sel_flush_addr_o <= wdata_i;
            state_q          <= StSel;
          end else if (wr_pf_start) begin
            pf_addr_o <= pf_addr_shadow;
            pf_size_o <= wdata_i[7:0];
            state_q   <= StPfReq;
          end
        end
        StByp: begin
          if (bypass_ack_i == {(NB_CORES + 1){bypass_req_o}}) begin
            state_q <= StIdle;
          end
        end
        StFlush: begin
          if (flush_ack_i) begin
            flush_req_o <= 1'b0;
            state_q     <= StIdle;
          end else begin
            flush_req_o <= 1'b1;
          end
        end
        StSel: begin
          if (sel_flush_ack_i) begin
            sel_flush_req_o <= 1'b0;
            state_q         <= StIdle;
          end else begin
            sel_flush_req_o <= 1'b1;
          end
        end
        StPfReq: begin
          if (pf_ack_i) begin
            pf_req_o <= 1'b0;
            state_q  <= pf_done_i ? StIdle : StPfWait;
          end else begin
            pf_req_o <= 1'b1;
          end
        end
        StPfWait: begin
          if (pf_done_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_ctrl_seq.sv
// Randomised scoreboard bench for icache_ctrl_seq with a register-level reference model and
// an automatic cache-side responder.
module tb_icache_ctrl_seq;

  localparam int unsigned NbCores = 8;
  localparam int unsigned IdW     = NbCores + 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_i;
  logic [31:0]      add_i;
  logic             wen_i;
  logic [31:0]      wdata_i;
  logic [3:0]       be_i;
  logic [IdW-1:0]   id_i;
  logic             gnt_o;
  logic             r_valid_o;
  logic             r_opc_o;
  logic [IdW-1:0]   r_id_o;
  logic [31:0]      r_rdata_o;
  logic             bypass_req_o;
  logic [NbCores:0] bypass_ack_i;
  logic             flush_req_o;
  logic             flush_ack_i;
  logic             sel_flush_req_o;
  logic [31:0]      sel_flush_addr_o;
  logic             sel_flush_ack_i;
  logic             pf_req_o;
  logic [31:0]      pf_addr_o;
  logic [7:0]       pf_size_o;
  logic             pf_ack_i;
  logic             pf_done_i;

  icache_ctrl_seq #(
    .NB_CORES (NbCores),
    .ID_WIDTH (IdW),
    .BYP_RST  (1'b1)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_i            (req_i),
    .add_i            (add_i),
    .wen_i            (wen_i),
    .wdata_i          (wdata_i),
    .be_i             (be_i),
    .id_i             (id_i),
    .gnt_o            (gnt_o),
    .r_valid_o        (r_valid_o),
    .r_opc_o          (r_opc_o),
    .r_id_o           (r_id_o),
    .r_rdata_o        (r_rdata_o),
    .bypass_req_o     (bypass_req_o),
    .bypass_ack_i     (bypass_ack_i),
    .flush_req_o      (flush_req_o),
    .flush_ack_i      (flush_ack_i),
    .sel_flush_req_o  (sel_flush_req_o),
    .sel_flush_addr_o (sel_flush_addr_o),
    .sel_flush_ack_i  (sel_flush_ack_i),
    .pf_req_o         (pf_req_o),
    .pf_addr_o        (pf_addr_o),
    .pf_size_o        (pf_size_o),
    .pf_ack_i         (pf_ack_i),
    .pf_done_i        (pf_done_i)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef enum int {PNone, PByp, PFlush, PSel, PPf} pend_e;
  typedef struct {
    int unsigned    cyc;
    logic           opc;
    logic [IdW-1:0] id;
    logic [31:0]    rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  // Reference model: software-visible register state plus the one outstanding command.
  bit          m_enabled;
  logic [31:0] m_pf_shadow;
  logic [31:0] m_pf_addr;
  logic [7:0]  m_pf_size;
  logic [31:0] m_sel_addr;
  pend_e       pend;
  int unsigned cmd_cyc;

  bit auto_resp     = 1'b1;
  int force_delay   = -1;
  int force_pf_same = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
  endtask

  task automatic model_reset();
    m_enabled   = 1'b0;
    m_pf_shadow = '0;
    m_pf_addr   = '0;
    m_pf_size   = '0;
    m_sel_addr  = '0;
    pend        = PNone;
  endtask

  function automatic logic [31:0] model_rdata(input logic [2:0] idx);
    case (idx)
      3'd0:    return {31'b0, m_enabled};
      3'd3:    return m_pf_shadow;
      3'd5:    return {29'b0, pend == PPf, pend != PNone, !m_enabled};
      default: return 32'h0;
    endcase
  endfunction

  task automatic start_cmd(input pend_e k);
    pend    = k;
    cmd_cyc = cyc;
  endtask

  task automatic model_write(input logic [2:0] idx, input logic [31:0] wd);
    case (idx)
      3'd0: if (wd[0] != m_enabled) begin
        m_enabled = wd[0];
        start_cmd(PByp);
      end
      3'd1: start_cmd(PFlush);
      3'd2: begin
        m_sel_addr = wd;
        start_cmd(PSel);
      end
      3'd3: m_pf_shadow = wd;
      3'd4: begin
        m_pf_addr = m_pf_shadow;
        m_pf_size = wd[7:0];
        start_cmd(PPf);
      end
      default: ;
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 after the grant cycle.
  task automatic do_req(input logic [2:0] idx, input logic rd, input logic [31:0] wd);
    logic [IdW-1:0] id;
    bit   is_cmd;
    bit   done;
    int   n;
    exp_t e;
    id      = IdW'($urandom);
    req_i   = 1'b1;
    add_i   = {27'($urandom), idx, 2'($urandom)};
    wen_i   = rd;
    wdata_i = wd;
    be_i    = 4'($urandom);
    id_i    = id;
    is_cmd  = !rd && (idx == 3'd0 || idx == 3'd1 || idx == 3'd2 || idx == 3'd4);
    done    = 1'b0;
    n       = 0;
    while (!done) begin
      @(negedge clk_i);
      check("gnt", {31'b0, gnt_o}, {31'b0, !(is_cmd && pend != PNone)});
      if (gnt_o) begin
        e.cyc   = cyc;
        e.opc   = idx > 3'd5;
        e.id    = id;
        e.rdata = rd ? model_rdata(idx) : 32'h0;
        exp_q.push_back(e);
        if (!rd) model_write(idx, wd);
        done = 1'b1;
      end else if (++n > 200) begin
        fail_now("gnt_timeout");
        done = 1'b1;
      end
      @(posedge clk_i);
      #1;
    end
    req_i = 1'b0;
    wen_i = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pend != PNone && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    if (pend != PNone) fail_now("idle_timeout");
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard monitor: every response must arrive exactly one cycle after its grant.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (exp_q.size() > 0 && exp_q[0].cyc + 1 < cyc) begin
        fail_now("missing_r_valid");
        void'(exp_q.pop_front());
      end
      if (r_valid_o) begin
        if (exp_q.size() == 0) begin
          fail_now("spurious_r_valid");
        end else begin
          mon_e = exp_q.pop_front();
          check("r_latency", cyc, mon_e.cyc + 1);
          check("r_opc", {31'b0, r_opc_o}, {31'b0, mon_e.opc});
          check("r_id", {23'b0, r_id_o}, {23'b0, mon_e.id});
          check("r_rdata", r_rdata_o, mon_e.rdata);
        end
      end
    end
  end

  function automatic logic req_of(input pend_e k);
    case (k)
      PFlush:  return flush_req_o;
      PSel:    return sel_flush_req_o;
      default: return pf_req_o;
    endcase
  endfunction

  task automatic check_payload(input pend_e k);
    check("req_held", {31'b0, req_of(k)}, 32'h1);
    if (k == PSel) check("sel_addr", sel_flush_addr_o, m_sel_addr);
    if (k == PPf) begin
      check("pf_addr", pf_addr_o, m_pf_addr);
      check("pf_size", {24'b0, pf_size_o}, {24'b0, m_pf_size});
    end
  endtask

  task automatic do_hs(input pend_e k);
    int n = 0;
    int d;
    int d2;
    bit same;
    while (req_of(k) == 1'b0 && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    if (req_of(k) == 1'b0) fail_now("req_rise_timeout");
    check("req_rise_cycle", cyc, cmd_cyc + 2);
    d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
    repeat (d) begin
      check_payload(k);
      @(negedge clk_i);
    end
    check_payload(k);
    same = (force_pf_same >= 0) ? (force_pf_same != 0) : bit'($urandom_range(0, 1));
    @(posedge clk_i);
    #1;
    case (k)
      PFlush: flush_ack_i = 1'b1;
      PSel:   sel_flush_ack_i = 1'b1;
      default: begin
        pf_ack_i  = 1'b1;
        pf_done_i = same;
      end
    endcase
    @(posedge clk_i);
    #1;
    flush_ack_i     = 1'b0;
    sel_flush_ack_i = 1'b0;
    pf_ack_i        = 1'b0;
    pf_done_i       = 1'b0;
    if (k == PPf && !same) begin
      @(negedge clk_i);
      check("req_drop", {31'b0, req_of(k)}, 32'h0);
      check("pf_addr_wait", pf_addr_o, m_pf_addr);
      d2 = $urandom_range(0, 3);
      repeat (d2) @(posedge clk_i);
      #1;
      pf_done_i = 1'b1;
      @(posedge clk_i);
      #1;
      pf_done_i = 1'b0;
      pend      = PNone;
    end else begin
      pend = PNone;
      @(negedge clk_i);
      check("req_drop", {31'b0, req_of(k)}, 32'h0);
    end
  endtask

  task automatic do_byp();
    logic [NbCores:0] tgt;
    int d;
    int i;
    while (cyc < cmd_cyc + 1) @(negedge clk_i);
    tgt = {(NbCores + 1){!m_enabled}};
    check("bypass_req", {31'b0, bypass_req_o}, {31'b0, !m_enabled});
    d = $urandom_range(0, 3);
    repeat (d) @(posedge clk_i);
    // Banks acknowledge one at a time in random order.
    while (bypass_ack_i != tgt) begin
      @(posedge clk_i);
      #1;
      do i = $urandom_range(0, NbCores); while (bypass_ack_i[i] == tgt[i]);
      bypass_ack_i[i] = tgt[i];
    end
    @(posedge clk_i);
    #1;
    pend = PNone;
  endtask

  initial begin : responder
    forever begin
      @(negedge clk_i);
      if (auto_resp && pend != PNone) begin
        if (pend == PByp) do_byp();
        else do_hs(pend);
      end
    end
  end

  initial begin : stimulus
    int n;
    int r;
    rst_i           = 1'b1;
    req_i           = 1'b0;
    add_i           = '0;
    wen_i           = 1'b1;
    wdata_i         = '0;
    be_i            = '0;
    id_i            = '0;
    bypass_ack_i    = '1;
    flush_ack_i     = 1'b0;
    sel_flush_ack_i = 1'b0;
    pf_ack_i        = 1'b0;
    pf_done_i       = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_bypass_req", {31'b0, bypass_req_o}, 32'h1);
    check("rst_flush_req", {31'b0, flush_req_o}, 32'h0);
    check("rst_sel_req", {31'b0, sel_flush_req_o}, 32'h0);
    check("rst_pf_req", {31'b0, pf_req_o}, 32'h0);
    check("rst_pf_addr", pf_addr_o, 32'h0);
    check("rst_sel_addr", sel_flush_addr_o, 32'h0);
    check("rst_r_valid", {31'b0, r_valid_o}, 32'h0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    do_req(3'd5, 1'b1, 32'h0);
    do_req(3'd0, 1'b0, 32'h1);
    do_req(3'd5, 1'b1, 32'h0);
    force_delay = 5;
    do_req(3'd1, 1'b0, 32'h0);
    do_req(3'd2, 1'b0, 32'h1234_5670);
    force_delay = -1;
    do_req(3'd3, 1'b0, 32'h1C00_8000);
    force_pf_same = 1;
    do_req(3'd4, 1'b0, 32'h10);
    do_req(3'd3, 1'b0, 32'h0BAD_F00C);
    wait_idle();
    do_req(3'd5, 1'b1, 32'h0);
    force_pf_same = -1;
    do_req(3'd6, 1'b1, 32'h0);
    do_req(3'd0, 1'b0, 32'h1);
    do_req(3'd5, 1'b1, 32'h0);

    wait_idle();
    auto_resp = 1'b0;
    do_req(3'd2, 1'b0, 32'hDEAD_BEE0);
    n = 0;
    while (!sel_flush_req_o && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    check("sel_req_pre_rst", {31'b0, sel_flush_req_o}, 32'h1);
    #1 rst_i = 1'b1;
    #1;
    check("rst_mid_sel_req", {31'b0, sel_flush_req_o}, 32'h0);
    check("rst_mid_sel_addr", sel_flush_addr_o, 32'h0);
    check("rst_mid_bypass", {31'b0, bypass_req_o}, 32'h1);
    bypass_ack_i = '1;
    model_reset();
    exp_q.delete();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    auto_resp = 1'b1;
    do_req(3'd5, 1'b1, 32'h0);

    repeat (300) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    do_req(3'($urandom), 1'b1, 32'h0);
        2:       do_req(3'd0, 1'b0, $urandom);
        3:       do_req(3'd1, 1'b0, $urandom);
        4:       do_req(3'd2, 1'b0, $urandom);
        5:       do_req(3'd3, 1'b0, $urandom);
        6:       do_req(3'd4, 1'b0, $urandom);
        7:       do_req(3'($urandom_range(5, 7)), 1'b0, $urandom);
        default: do_req(3'd5, 1'b1, 32'h0);
      endcase
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_i);
        #1;
      end
    end
    wait_idle();
    repeat (3) @(posedge clk_i);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
